ddr_rx_gearbox: RTL
===================

Name: ddr_rx_gearbox

Overview:
- Fabric-side deserializer directly downstream of the I_DDR input primitive.
- Each cycle, consumes the 2-bit DDR sample pair from I_DDR Q[1:0] and assembles LSB-first WIDTH-bit words.
- Supports 1-bit word-boundary alignment (bitslip) and buffers completed words in a small show-ahead FIFO with a valid/ready output.
- The overflow condition is reported as a sticky flag.

Parameters:
- WIDTH, 8, output word width in bits; legal range 3..16.
- DEPTH, 4, output FIFO entries; power of 2, range 2..16.

Ports:
- C  input  1  fabric clock; same clock as the I_DDR C pin.
- R  input  1  reset, asynchronous, active-high.
- D  input  2  sample pair from I_DDR Q; D[0] = rising-edge bit (earlier in time), D[1] = falling-edge bit.
- EN  input  1  sample enable; D is consumed only on cycles with EN=1.
- BITSLIP  input  1  request to drop one incoming bit (shifts the word boundary by +1 bit).
- DATA_O  output  WIDTH  head-of-FIFO word; the first-received bit is in DATA_O[0].
- VALID_O  output  1  FIFO non-empty.
- READY_I  input  1  consumer accepts DATA_O when VALID_O&READY_I.
- FILL_LEVEL  output  $clog2(DEPTH)+1  current FIFO occupancy.
- OVERFLOW  output  1  sticky; a completed word was dropped.
- CLR_OVF  input  1  synchronous clear of OVERFLOW.

Behaviour:
- Reset (R=1, async): accumulator=0, bit count cnt=0, slip_pend=0, FIFO empty; DATA_O=0, VALID_O=0, FILL_LEVEL=0, OVERFLOW=0. A reset asserted mid-word discards the partial word.
- Accumulator: width WIDTH+1; cnt range 0..WIDTH-1.
- Normal EN cycle: append D[0] at position cnt and D[1] at cnt+1 (nbits=2).
- Bitslip:
  - BITSLIP=1 sets slip_pend.
  - On the next EN cycle with slip_pend=1 (including the same cycle as BITSLIP), D[0] is discarded and only D[1] is appended at cnt (nbits=1); slip_pend is then cleared.
  - BITSLIP while slip_pend=1 is ignored; slips do not accumulate.
- Word completion: on the EN edge where cnt+nbits >= WIDTH:
  - Push accumulator[WIDTH-1:0] to the FIFO.
  - Move any remainder bit (accumulator[WIDTH]) to position 0.
  - cnt := cnt+nbits-WIDTH (0 or 1).
  - At most one word completes per cycle.
- Latency: a completed word appears on DATA_O with VALID_O=1 one cycle after the completing edge, when the FIFO was empty.
- FIFO rules:
  - Show-ahead: DATA_O = head entry. DATA_O holds its last value when VALID_O=0 (0 after reset).
  - Pop on VALID_O&READY_I.
  - Push while full with a simultaneous pop: the push is accepted, FILL_LEVEL is unchanged.
  - Push while full with no pop: the word is dropped and OVERFLOW:=1. Stored entries are untouched.
  - Pointers wrap modulo DEPTH; FILL_LEVEL counts 0..DEPTH.
- OVERFLOW:
  - Cleared by CLR_OVF on the next edge.
  - A new overflow in the same cycle as CLR_OVF wins (OVERFLOW stays 1).
- EN=0: accumulator, cnt and the FIFO push path hold; pops still proceed.

Decomposition:
- Package ddr_rx_gearbox_pkg holds WIDTH_MIN=3, WIDTH_MAX=16 and DEPTH_MAX=16.
- Sub-module ddr_rx_fifo: synchronous show-ahead FIFO (WIDTH, DEPTH) with push, pop, full, empty and level outputs.
- Bit accumulation, bitslip and overflow logic stay in the top module.

Test Plan:
- Basic assembly: WIDTH=8; EN=1; D=2'b01, 2'b01, 2'b10, 2'b10 -> VALID_O=1 one cycle after the 4th edge; DATA_O=8'hA5; FILL_LEVEL=1.
- Continuous stream with bitslip: repeating 0xA5 stream with READY_I=1; one BITSLIP pulse at cnt=0 -> next completed word is 8'hD2 and all later words are 8'hD2. A second BITSLIP while slip_pend=1 produces no extra shift.
- EN gaps: same 0xA5 pairs with EN=0 cycles interleaved -> same 8'hA5 word; completion happens only on EN edges.
- Overflow: DEPTH=4, READY_I=0, five 0xA5 words pushed -> FILL_LEVEL=4 and OVERFLOW=1 after the 5th completion. Draining returns exactly 4 words of 8'hA5. CLR_OVF -> OVERFLOW=0.
- Full with simultaneous pop and push: FILL_LEVEL=4, READY_I=1 on the completing edge -> FILL_LEVEL stays 4 and OVERFLOW stays 0.
- Reset mid-word: R pulsed at cnt=4 -> all outputs 0 asynchronously. After release, 4 fresh pairs yield a clean 8'hA5.

Source files
------------

// File: rtl/ddr_rx_gearbox_pkg.sv
// ddr_rx_gearbox_pkg
//   Shared limits for the DDR receive gearbox and its output FIFO.
//   WIDTH_MIN/WIDTH_MAX bound the assembled word width. DEPTH_MAX bounds
//   the output FIFO depth.
package ddr_rx_gearbox_pkg;

    localparam int WIDTH_MIN = 3;
    localparam int WIDTH_MAX = 16;
    localparam int DEPTH_MAX = 16;

endpackage

// File: rtl/ddr_rx_fifo.sv
// ddr_rx_fifo
//   Synchronous show-ahead FIFO with a registered head output.
//   dout always shows the oldest stored word. When the FIFO runs empty,
//   dout keeps the last word it showed, and it is 0 after reset.
// Ports:
//   clk    clock
//   rst    asynchronous active-high reset
//   push   write din. The write is accepted when not full, or when full
//          and a pop happens in the same cycle.
//   pop    remove the head entry. It is ignored when empty.
//   din    write data
//   dout   head-of-FIFO data
//   full   level == DEPTH
//   empty  level == 0
//   level  occupancy, 0..DEPTH
module ddr_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_inc;
    logic [LW-1:0]    level_q;
    logic [WIDTH-1:0] dout_q;
    logic             do_push;
    logic             do_pop;

    assign empty      = (level_q == '0);
    assign full       = (level_q == LW'(DEPTH));
    assign do_pop     = pop & ~empty;
    // A full FIFO can still take a word when the head leaves in the same cycle.
    assign do_push    = push & (~full | do_pop);
    // DEPTH is a power of two, so the pointers wrap naturally.
    assign rd_ptr_inc = rd_ptr + AW'(1);

    // NOTE: the storage array has no reset. Only pointers, level and the head
    // register need a known state, and leaving the array unreset keeps it in RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side below reads the value from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            dout_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr_inc;
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase

            // The registered head tracks the entry that is oldest after this edge.
            if (do_pop) begin
                if (level_q > LW'(1)) begin
                    dout_q <= mem[rd_ptr_inc];
                end else if (do_push) begin
                    dout_q <= din;
                end
            end else if (empty && do_push) begin
                dout_q <= din;
            end
        end
    end

    assign dout  = dout_q;
    assign level = level_q;

endmodule

// File: rtl/ddr_rx_gearbox.sv
// ddr_rx_gearbox
//   Fabric-side deserializer placed after an I_DDR input primitive. Each
//   enabled cycle it takes the rising/falling sample pair D and packs the
//   bits LSB-first into WIDTH-bit words. A bitslip drops one incoming bit,
//   which moves the word boundary by one bit. Completed words wait in a
//   show-ahead FIFO that has a valid/ready interface.
// Ports:
//   C           fabric clock. This is the same clock as the I_DDR C pin.
//   R           asynchronous active-high reset
//   D[1:0]      D[0] is the rising-edge bit (earlier), D[1] the falling-edge bit
//   EN          D is consumed only when EN=1
//   BITSLIP     request to drop the next incoming bit. Requests do not stack.
//   DATA_O      head word. Its first received bit is DATA_O[0].
//   VALID_O     FIFO not empty
//   READY_I     consumer takes DATA_O when VALID_O & READY_I
//   FILL_LEVEL  FIFO occupancy, 0..DEPTH
//   OVERFLOW    sticky. A completed word was dropped because the FIFO was full.
//   CLR_OVF     synchronous clear of OVERFLOW. A new overflow in the same
//               cycle wins.
module ddr_rx_gearbox
    import ddr_rx_gearbox_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     C,
    input  logic                     R,
    input  logic [1:0]               D,
    input  logic                     EN,
    input  logic                     BITSLIP,
    output logic [WIDTH-1:0]         DATA_O,
    output logic                     VALID_O,
    input  logic                     READY_I,
    output logic [$clog2(DEPTH):0]   FILL_LEVEL,
    output logic                     OVERFLOW,
    input  logic                     CLR_OVF
);

    generate
        if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
            $error("ddr_rx_gearbox: WIDTH out of range");
        end
        if (DEPTH < 2 || DEPTH > DEPTH_MAX || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("ddr_rx_gearbox: DEPTH must be a power of two in 2..16");
        end
    endgenerate

    // The count must hold cnt+2 before the wrap check.
    localparam int CW = $clog2(WIDTH + 2);

    logic [WIDTH:0]   acc_q;
    logic [WIDTH:0]   acc_fill;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_sum;
    logic             slip_pend_q;
    logic             slip_now;
    logic             complete;
    logic             pop;
    logic             drop;
    logic             overflow_q;
    logic             fifo_full;
    logic             fifo_empty;

    // The accumulator with this cycle's bits merged in. It has one spare bit
    // above the word so that a pair which straddles the boundary fits.
    // NOTE: every always_comb output gets a default before any conditional
    // update, so no path leaves a latch behind.
    always_comb begin
        slip_now = slip_pend_q | BITSLIP;
        acc_fill = acc_q;
        for (int i = 0; i <= WIDTH; i++) begin
            if (slip_now) begin
                if (CW'(i) == cnt_q) acc_fill[i] = D[1];
            end else begin
                if (CW'(i) == cnt_q)          acc_fill[i] = D[0];
                if (CW'(i) == cnt_q + CW'(1)) acc_fill[i] = D[1];
            end
        end
        cnt_sum  = cnt_q + (slip_now ? CW'(1) : CW'(2));
        complete = EN & (cnt_sum >= CW'(WIDTH));
    end

    assign pop  = VALID_O & READY_I;
    assign drop = complete & fifo_full & ~pop;

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            slip_pend_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (EN) begin
                if (complete) begin
                    // Only a bit that spilled past the word carries over into the next word.
                    acc_q <= {{WIDTH{1'b0}}, (cnt_sum > CW'(WIDTH)) & acc_fill[WIDTH]};
                    cnt_q <= cnt_sum - CW'(WIDTH);
                end else begin
                    acc_q <= acc_fill;
                    cnt_q <= cnt_sum;
                end
                // Any pending or same-cycle slip is used up by this enabled sample.
                slip_pend_q <= 1'b0;
            end else if (BITSLIP) begin
                slip_pend_q <= 1'b1;
            end

            if (drop) begin
                overflow_q <= 1'b1;
            end else if (CLR_OVF) begin
                overflow_q <= 1'b0;
            end
        end
    end

    ddr_rx_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (C),
        .rst   (R),
        .push  (complete),
        .pop   (pop),
        .din   (acc_fill[WIDTH-1:0]),
        .dout  (DATA_O),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (FILL_LEVEL)
    );

    assign VALID_O  = ~fifo_empty;
    assign OVERFLOW = overflow_q;

endmodule
